ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 14 +
 rtl/ram_port_arbiter_rr_picker.sv | 34 +++
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared state encoding and default sizing for the RAM port arbiter
package ram_port_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int N_REQ_DEF  = 4;
   localparam int ADDR_W_DEF = 10;
   localparam int LEN_W_DEF  = 5;
   localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// rtl/ram_port_arbiter_rr_picker.sv - round-robin winner pick starting at ptr, with a candidate mask
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] mask_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [N_REQ-1:0] winner_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N_REQ-1:0] cand;

   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      idx_o    = '0;
      cand     = req_i & ~mask_i;
      // Walk offsets from farthest to nearest so the candidate closest to ptr is written last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr_i) + k) % N_REQ;
         if (cand[j]) begin
            valid_o     = 1'b1;
            winner_o    = '0;
            winner_o[j] = 1'b1;
            idx_o       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin burst arbiter in front of a single-read-port RAM
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*LEN_W-1:0]  req_len,
   output logic [N_REQ-1:0]        gnt,
   output logic                    ram_en,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [N_REQ-1:0]        burst_done,
   output logic                    busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;

   logic [RD_LAT-1:0]  pv_q, pl_q;
   logic [IDX_W-1:0]   po_q [RD_LAT];

   logic [N_REQ-1:0]   mask;
   logic               last_beat;
   logic               take;
   logic               pick_valid;
   logic [N_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]   pick_idx;

   assign last_beat = (state_q == ST_BURST) && (beat_q == len_q);

   // The owner only competes when its burst is ending, and then it must yield.
   always_comb begin
      mask = '0;
      if (state_q == ST_BURST) mask[owner_q] = 1'b1;
   end

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
      .req_i    (req),
      .mask_i   (mask),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_onehot),
      .idx_o    (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      len_d   = len_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      gnt_d   = '0;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            take = pick_valid;
         end
         ST_BURST: begin
            if (!last_beat) begin
               beat_d = beat_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end else if (pick_valid) begin
               take = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (take) begin
         state_d = ST_BURST;
         owner_d = pick_idx;
         len_d   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
         addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
         beat_d  = '0;
         gnt_d   = pick_onehot;
         ptr_d   = IDX_W'((int'(pick_idx) + 1) % N_REQ);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         gnt_q   <= gnt_d;
      end
   end

   // Each beat carries its owner and last flag so returning data is steered correctly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pv_q <= '0;
         pl_q <= '0;
         for (int i = 0; i < RD_LAT; i++) po_q[i] <= '0;
      end else begin
         pv_q[0] <= (state_q == ST_BURST);
         pl_q[0] <= last_beat;
         po_q[0] <= owner_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pl_q[i] <= pl_q[i-1];
            po_q[i] <= po_q[i-1];
         end
      end
   end

   always_comb begin
      rd_valid   = '0;
      burst_done = '0;
      if (pv_q[RD_LAT-1]) begin
         rd_valid[po_q[RD_LAT-1]]   = 1'b1;
         burst_done[po_q[RD_LAT-1]] = pl_q[RD_LAT-1];
      end
   end

   assign gnt      = gnt_q;
   assign ram_en   = (state_q == ST_BURST);
   assign ram_addr = addr_q;
   assign busy     = (state_q == ST_BURST) || (|pv_q);

endmodule
